// File: rtl/stage_mem_ctrl_pkg.sv
// Shared definitions for the MFCC stage controllers: the stage FSM state
// encoding and the default frame geometry used by the top controller.
package stage_mem_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_FRAME_LEN  = 400;
  localparam int DEF_PIPE_LAT   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } stage_state_e;

endpackage

// File: rtl/stage_addr_cnt.sv
// Address counter with synchronous clear, count enable and a terminal-count
// flag. The count saturates at TC_VAL, so it never leaves the frame range.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_clr      : return the count to 0 (wins over i_en)
//   i_en       : advance by one unless already at TC_VAL
//   o_cnt      : current address
//   o_tc       : o_cnt == TC_VAL
module stage_addr_cnt #(
  parameter int WIDTH  = 9,
  parameter int TC_VAL = 399
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_tc;

  assign w_tc  = (r_cnt == WIDTH'(TC_VAL));
  assign o_cnt = r_cnt;
  assign o_tc  = w_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stage_mem_ctrl.sv
// Ping-pong memory sequencer for one processing stage. A start pulse reads a
// full frame from the source bank; the read strobe is delayed through a
// PIPE_LAT-deep valid pipe to become the write strobe into the destination
// bank. Banks are captured at start and held for the whole frame.
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   state_en                  : start pulse
//   src_mem_sel, dst_mem_sel  : banks for this frame (captured at start)
//   rd_en/rd_bank/rd_addr     : source read strobe, bank, address
//   wr_en/wr_bank/wr_addr     : destination write strobe, bank, address
//   first_sample              : read of address 0 (datapath clears history)
//   busy                      : frame in progress (READ, DRAIN, DONE)
//   stage_done                : frame fully written
//   start_err                 : start pulse seen while not idle
//
// state    | meaning
// ST_IDLE  | waiting for state_en
// ST_READ  | rd_en every cycle, rd_addr 0..FRAME_LEN-1
// ST_DRAIN | reads finished, waiting for the last write to retire
// ST_DONE  | stage_done pulse, back to idle next cycle
module stage_mem_ctrl
  import stage_mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int PIPE_LAT   = DEF_PIPE_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  state_en,
  input  logic                  src_mem_sel,
  input  logic                  dst_mem_sel,
  output logic                  rd_en,
  output logic                  rd_bank,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  wr_en,
  output logic                  wr_bank,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  first_sample,
  output logic                  busy,
  output logic                  stage_done,
  output logic                  start_err
);

  if ((FRAME_LEN < 1) || (FRAME_LEN > (2 ** ADDR_WIDTH))) begin : g_bad_frame_len
    $error("stage_mem_ctrl: FRAME_LEN must be in 1..2**ADDR_WIDTH");
  end
  if ((PIPE_LAT < 1) || (PIPE_LAT > 8)) begin : g_bad_pipe_lat
    $error("stage_mem_ctrl: PIPE_LAT must be in 1..8");
  end

  stage_state_e        r_state;
  stage_state_e        w_state_nxt;
  logic                w_accept;
  logic                w_rd_tc;
  logic                w_wr_tc;
  logic                r_rd_bank;
  logic                r_wr_bank;
  logic                r_start_err;
  logic [PIPE_LAT-1:0] r_vld_sr;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    rd_en       = 1'b0;
    busy        = 1'b1;
    stage_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (state_en) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        rd_en = 1'b1;
        if (w_rd_tc) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The last write always lands here: it trails the last read by
        // PIPE_LAT >= 1 cycles.
        if (wr_en && w_wr_tc) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        stage_done  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rd_bank   <= 1'b0;
      r_wr_bank   <= 1'b0;
      r_start_err <= 1'b0;
      r_vld_sr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      // Any start outside IDLE (including the DONE cycle) is rejected.
      r_start_err <= state_en && (r_state != ST_IDLE);
      if (w_accept) begin
        r_rd_bank <= src_mem_sel;
        r_wr_bank <= dst_mem_sel;
      end
      r_vld_sr[0] <= rd_en;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_vld_sr[i] <= r_vld_sr[i-1];
      end
    end
  end

  stage_addr_cnt #(
    .WIDTH  (ADDR_WIDTH),
    .TC_VAL (FRAME_LEN - 1)
  ) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_accept),
    .i_en  (rd_en),
    .o_cnt (rd_addr),
    .o_tc  (w_rd_tc)
  );

  stage_addr_cnt #(
    .WIDTH  (ADDR_WIDTH),
    .TC_VAL (FRAME_LEN - 1)
  ) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_accept),
    .i_en  (wr_en),
    .o_cnt (wr_addr),
    .o_tc  (w_wr_tc)
  );

  assign wr_en        = r_vld_sr[PIPE_LAT-1];
  assign rd_bank      = r_rd_bank;
  assign wr_bank      = r_wr_bank;
  assign start_err    = r_start_err;
  assign first_sample = rd_en && (rd_addr == '0);

endmodule

// File: tb/tb_stage_mem_ctrl.sv
// Bench for stage_mem_ctrl: two instances (default geometry and a short
// FRAME_LEN=4/PIPE_LAT=1 one) compared every cycle against a frame-timing
// model that works from the cycle offset since the accepted start.
module tb_stage_mem_ctrl;

  localparam int AW_A = 9, FL_A = 400, PL_A = 3;
  localparam int AW_B = 3, FL_B = 4,   PL_B = 1;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic            a_rst_n, a_state_en, a_src, a_dst;
  logic            a_rd_en, a_rd_bank, a_wr_en, a_wr_bank;
  logic [AW_A-1:0] a_rd_addr, a_wr_addr;
  logic            a_first, a_busy, a_done, a_err;

  logic            b_rst_n, b_state_en, b_src, b_dst;
  logic            b_rd_en, b_rd_bank, b_wr_en, b_wr_bank;
  logic [AW_B-1:0] b_rd_addr, b_wr_addr;
  logic            b_first, b_busy, b_done, b_err;

  stage_mem_ctrl #(.ADDR_WIDTH(AW_A), .FRAME_LEN(FL_A), .PIPE_LAT(PL_A)) u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .state_en(a_state_en),
    .src_mem_sel(a_src), .dst_mem_sel(a_dst),
    .rd_en(a_rd_en), .rd_bank(a_rd_bank), .rd_addr(a_rd_addr),
    .wr_en(a_wr_en), .wr_bank(a_wr_bank), .wr_addr(a_wr_addr),
    .first_sample(a_first), .busy(a_busy), .stage_done(a_done), .start_err(a_err)
  );

  stage_mem_ctrl #(.ADDR_WIDTH(AW_B), .FRAME_LEN(FL_B), .PIPE_LAT(PL_B)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .state_en(b_state_en),
    .src_mem_sel(b_src), .dst_mem_sel(b_dst),
    .rd_en(b_rd_en), .rd_bank(b_rd_bank), .rd_addr(b_rd_addr),
    .wr_en(b_wr_en), .wr_bank(b_wr_bank), .wr_addr(b_wr_addr),
    .first_sample(b_first), .busy(b_busy), .stage_done(b_done), .start_err(b_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cur_d   = 0;

  // stimulus for each instance, applied just after the rising edge
  bit en_v[2], src_v[2], dst_v[2], rstn_v[2];

  // model: last accepted start cycle and captured banks per instance
  bit has_frame[2], m_rb[2], m_wb[2], err_exp[2];
  int m_s[2];
  int fl_v[2], pl_v[2];

  // observed strobe tallies for frame-level checks
  int cnt_rd[2], cnt_wr[2], cnt_done[2], cnt_err[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s dut=%0d cyc=%0d got=%0d expected=%0d", tag, cur_d, cyc, obs, exp);
    end
  endtask

  task automatic step();
    int  k, fl, pl, e_ra, e_wa;
    bit  e_busy, e_rd, e_wr, e_done, e_first, e_rb, e_wb;
    logic o_rd, o_wr, o_rb, o_wb, o_first, o_busy, o_done, o_err;
    logic [31:0] o_ra, o_wa;
    @(posedge clk);
    cyc++;
    #1;
    a_rst_n = rstn_v[0]; a_state_en = en_v[0]; a_src = src_v[0]; a_dst = dst_v[0];
    b_rst_n = rstn_v[1]; b_state_en = en_v[1]; b_src = src_v[1]; b_dst = dst_v[1];
    for (int d = 0; d < 2; d++) begin
      if (!rstn_v[d]) begin
        has_frame[d] = 1'b0;
        err_exp[d]   = 1'b0;
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      cur_d = d;
      fl = fl_v[d];
      pl = pl_v[d];
      e_busy = 0; e_rd = 0; e_wr = 0; e_done = 0; e_first = 0;
      e_ra = 0; e_wa = 0; e_rb = 0; e_wb = 0;
      if (has_frame[d]) begin
        k       = cyc - m_s[d];
        e_busy  = (k >= 1) && (k <= fl + pl + 1);
        e_rd    = (k >= 1) && (k <= fl);
        e_first = (k == 1);
        e_ra    = (k <= fl) ? k - 1 : fl - 1;
        e_wr    = (k >= pl + 1) && (k <= fl + pl);
        e_wa    = (k <= pl) ? 0 : ((k <= fl + pl) ? k - pl - 1 : fl - 1);
        e_done  = (k == fl + pl + 1);
        e_rb    = m_rb[d];
        e_wb    = m_wb[d];
      end
      if (d == 0) begin
        o_rd = a_rd_en; o_wr = a_wr_en; o_rb = a_rd_bank; o_wb = a_wr_bank;
        o_ra = 32'(a_rd_addr); o_wa = 32'(a_wr_addr);
        o_first = a_first; o_busy = a_busy; o_done = a_done; o_err = a_err;
      end else begin
        o_rd = b_rd_en; o_wr = b_wr_en; o_rb = b_rd_bank; o_wb = b_wr_bank;
        o_ra = 32'(b_rd_addr); o_wa = 32'(b_wr_addr);
        o_first = b_first; o_busy = b_busy; o_done = b_done; o_err = b_err;
      end
      chk("rd_en",        32'(o_rd),    32'(e_rd));
      chk("rd_addr",      o_ra,         32'(e_ra));
      chk("rd_bank",      32'(o_rb),    32'(e_rb));
      chk("wr_en",        32'(o_wr),    32'(e_wr));
      chk("wr_addr",      o_wa,         32'(e_wa));
      chk("wr_bank",      32'(o_wb),    32'(e_wb));
      chk("first_sample", 32'(o_first), 32'(e_first));
      chk("busy",         32'(o_busy),  32'(e_busy));
      chk("stage_done",   32'(o_done),  32'(e_done));
      chk("start_err",    32'(o_err),   32'(err_exp[d]));
      cnt_rd[d]   += int'(o_rd === 1'b1);
      cnt_wr[d]   += int'(o_wr === 1'b1);
      cnt_done[d] += int'(o_done === 1'b1);
      cnt_err[d]  += int'(o_err === 1'b1);
      if (rstn_v[d]) begin
        err_exp[d] = en_v[d] && e_busy;
        if (en_v[d] && !e_busy) begin
          has_frame[d] = 1'b1;
          m_s[d]       = cyc;
          m_rb[d]      = src_v[d];
          m_wb[d]      = dst_v[d];
        end
      end
    end
  endtask

  task automatic clear_tallies();
    for (int d = 0; d < 2; d++) begin
      cnt_rd[d] = 0; cnt_wr[d] = 0; cnt_done[d] = 0; cnt_err[d] = 0;
    end
  endtask

  initial begin
    fl_v[0] = FL_A; pl_v[0] = PL_A;
    fl_v[1] = FL_B; pl_v[1] = PL_B;
    for (int d = 0; d < 2; d++) begin
      en_v[d] = 0; src_v[d] = 0; dst_v[d] = 0; rstn_v[d] = 0;
      has_frame[d] = 0; err_exp[d] = 0; m_s[d] = 0; m_rb[d] = 0; m_wb[d] = 0;
    end
    a_rst_n = 0; a_state_en = 0; a_src = 0; a_dst = 0;
    b_rst_n = 0; b_state_en = 0; b_src = 0; b_dst = 0;

    // reset state
    repeat (3) step();
    rstn_v[0] = 1; rstn_v[1] = 1;
    repeat (3) step();

    // first frame src=1/dst=0 with sel toggling and a start attempt at rd_addr 100
    clear_tallies();
    en_v[0] = 1; src_v[0] = 1; dst_v[0] = 0;
    step();
    en_v[0] = 0;
    for (int i = 0; i < FL_A + PL_A + 4; i++) begin
      src_v[0] = 1'($urandom_range(0, 1));
      dst_v[0] = 1'($urandom_range(0, 1));
      en_v[0]  = (i == 100);
      step();
    end
    en_v[0] = 0;
    cur_d = 0;
    chk("frame_rd_count",   32'(cnt_rd[0]),   32'(FL_A));
    chk("frame_wr_count",   32'(cnt_wr[0]),   32'(FL_A));
    chk("frame_done_count", 32'(cnt_done[0]), 32'd1);
    chk("frame_err_count",  32'(cnt_err[0]),  32'd1);

    // random starts and bank selects on both instances
    for (int i = 0; i < 1500; i++) begin
      en_v[0]  = ($urandom_range(0, 199) == 0);
      src_v[0] = 1'($urandom_range(0, 1));
      dst_v[0] = 1'($urandom_range(0, 1));
      en_v[1]  = ($urandom_range(0, 2) == 0);
      src_v[1] = 1'($urandom_range(0, 1));
      dst_v[1] = 1'($urandom_range(0, 1));
      step();
    end
    en_v[0] = 0; en_v[1] = 0;
    repeat (FL_A + PL_A + 4) step();

    // reset while writing address 200, then a clean restart
    en_v[0] = 1; src_v[0] = 0; dst_v[0] = 1;
    step();
    en_v[0] = 0;
    repeat (PL_A + 200) step();
    rstn_v[0] = 0;
    step();
    step();
    clear_tallies();
    rstn_v[0] = 1;
    repeat (PL_A + 3) step();
    cur_d = 0;
    chk("abort_wr_count",   32'(cnt_wr[0]),   32'd0);
    chk("abort_done_count", 32'(cnt_done[0]), 32'd0);
    en_v[0] = 1; src_v[0] = 1; dst_v[0] = 1;
    step();
    en_v[0] = 0;
    repeat (FL_A + PL_A + 3) step();

    // short instance: back-to-back starts on the cycle after stage_done
    clear_tallies();
    for (int r = 0; r < 4; r++) begin
      en_v[1]  = 1;
      src_v[1] = 1'(r);
      dst_v[1] = 1'(~r);
      step();
      en_v[1] = 0;
      repeat (FL_B + PL_B + 1) step();
    end
    step();
    cur_d = 1;
    chk("b2b_done_count", 32'(cnt_done[1]), 32'd4);
    chk("b2b_err_count",  32'(cnt_err[1]),  32'd0);

    // short instance: start landing on the stage_done cycle is rejected
    clear_tallies();
    en_v[1] = 1;
    step();
    en_v[1] = 0;
    repeat (FL_B + PL_B) step();
    en_v[1] = 1;
    step();
    en_v[1] = 0;
    repeat (3) step();
    cur_d = 1;
    chk("done_cycle_err_count",  32'(cnt_err[1]),  32'd1);
    chk("done_cycle_done_count", 32'(cnt_done[1]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_mem_ctrl.md
STAGE_MEM_CTRL -- requirements
Module: stage_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9: width of the ping-pong memory address.
REQ-002 SHALL have parameter FRAME_LEN, default 400: samples per frame processed per enable.
REQ-003 SHALL have parameter PIPE_LAT, default 3: cycles from rd_en to matching wr_en (1..8).
REQ-004 SHALL have port clk  input  1: single clock; all flops on rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port state_en  input  1: one-cycle start pulse from top controller state machine.
REQ-007 SHALL have port src_mem_sel  input  1: ping-pong bank holding this stage's input.
REQ-008 SHALL have port dst_mem_sel  input  1: ping-pong bank receiving this stage's output.
REQ-009 SHALL have port rd_en  output  1: source memory read strobe.
REQ-010 SHALL have port rd_bank  output  1: bank addressed by rd_en.
REQ-011 SHALL have port rd_addr  output  ADDR_WIDTH: source read address.
REQ-012 SHALL have port wr_en  output  1: destination memory write strobe.
REQ-013 SHALL have port wr_bank  output  1: bank addressed by wr_en.
REQ-014 SHALL have port wr_addr  output  ADDR_WIDTH: destination write address.
REQ-015 SHALL have port first_sample  output  1: high with rd_en for address 0 (datapath clears history, e.g. pre-emphasis x[-1]=0).
REQ-016 SHALL have port busy  output  1: high from the cycle after accepted start through DONE.
REQ-017 SHALL have port stage_done  output  1: one-cycle pulse, frame fully written.
REQ-018 SHALL have port start_err  output  1: one-cycle pulse, state_en received while busy.

Function
REQ-019 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-020 IDLE: on state_en=1 SHALL latch src_mem_sel/dst_mem_sel into rd_bank/wr_bank, clear both counters, go to READ.
REQ-021 READ: SHALL assert rd_en every cycle, rd_addr 0,1,..,FRAME_LEN-1; after address FRAME_LEN-1 go to DRAIN.
REQ-022 SHALL delay rd_en through a PIPE_LAT-deep valid shift register; its output is wr_en.
REQ-023 SHALL increment wr_addr after each wr_en; first write at wr_addr 0, exactly PIPE_LAT cycles after first rd_en.
REQ-024 DRAIN: rd_en=0; when the write at wr_addr FRAME_LEN-1 occurs SHALL go to DONE.
REQ-025 DONE: SHALL pulse stage_done for one cycle, then IDLE; total start-to-done = 1+FRAME_LEN+PIPE_LAT cycles.
REQ-026 rd_bank/wr_bank SHALL hold latched values for the whole frame regardless of sel input changes.
REQ-027 state_en while not IDLE SHALL be ignored (no restart) and pulse start_err next cycle.
REQ-028 state_en arriving in the same cycle as stage_done SHALL be treated as busy (start_err); next pulse in IDLE accepted.
REQ-029 Counters SHALL never exceed FRAME_LEN-1; FRAME_LEN > 2**ADDR_WIDTH is a parameter error (elaboration assertion).
REQ-030 rd_addr/wr_addr SHALL hold last value when not strobed; first_sample=0 outside READ address 0.

Reset
REQ-031 rst_n=0 SHALL force IDLE, shift register empty, all outputs 0, counters 0, banks 0, asynchronously.
REQ-032 Reset mid-frame SHALL abort with no further rd_en/wr_en and no stage_done.

Structure
REQ-033 FSM state encoding and default ADDR_WIDTH/FRAME_LEN constants SHALL reside in the shared MFCC package used by the top controller.
REQ-034 One sub-module SHALL be natural: stage_addr_cnt (enable/clear/terminal-count counter), instantiated for read and write addresses.

Verification
REQ-035 Reset release, state_en at cycle 5, src=1,dst=0 -> rd_en cycles 6..405 addr 0..399 bank 1; wr_en cycles 9..408 bank 0; stage_done at 409.
REQ-036 src_mem_sel/dst_mem_sel toggled during READ -> rd_bank/wr_bank unchanged until frame end.
REQ-037 state_en at rd_addr 100 -> start_err pulse, addresses continue uninterrupted, single stage_done.
REQ-038 rst_n low at wr_addr 200 -> outputs 0 immediately; new state_en restarts from addr 0.
REQ-039 FRAME_LEN=4, PIPE_LAT=1, back-to-back state_en on cycle after stage_done -> second frame accepted, 6-cycle latency each.
